// File: rtl/tmds_rx_channel.sv
// Single-lane TMDS receiver: serial-to-parallel shift, word alignment from
// control tokens, and decode of each aligned 10-bit word to data or control.
//
// Handshake: valid_out is a one-cycle strobe with no ready; data_out,
// ctrl_out and de_out are meaningful in the cycle valid_out is high and
// hold their last values otherwise.
module tmds_rx_channel #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

    state_t     state, state_n;
    logic [9:0] sr;
    logic [3:0] phase, phase_n;
    logic [3:0] hits, hits_n;
    logic [3:0] mis, mis_n;
    logic       seen, seen_n;

    logic       token_match;
    logic [1:0] token_val;
    logic       boundary;
    logic [7:0] b_word;
    logic [7:0] dec_data;
    logic       emit;

    assign boundary = (phase == 4'd0);

    // Deserialiser: newest bit enters at the top, so sr[0] is the oldest bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= 10'd0;
        end else begin
            sr <= {serial_in, sr[9:1]};
        end
    end

    // Compare the current window against the four control tokens.
    always_comb begin
        token_match = 1'b1;
        token_val   = 2'b00;
        case (sr)
            10'h354: token_val = 2'b00;
            10'h0AB: token_val = 2'b01;
            10'h154: token_val = 2'b10;
            10'h2AB: token_val = 2'b11;
            default: token_match = 1'b0;
        endcase
    end

    // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
    always_comb begin
        dec_data    = 8'h00;
        b_word      = sr[9] ? ~sr[7:0] : sr[7:0];
        dec_data[0] = b_word[0];
        for (int i = 1; i < 8; i++) begin
            dec_data[i] = sr[8] ? (b_word[i] ^ b_word[i-1])
                                : ~(b_word[i] ^ b_word[i-1]);
        end
    end

    // State register plus the alignment counters that travel with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
            phase <= 4'd0;
            hits  <= 4'd0;
            mis   <= 4'd0;
            seen  <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            hits  <= hits_n;
            mis   <= mis_n;
            seen  <= seen_n;
        end
    end

    // Next-state logic: acquire alignment, confirm it, and watch for slips.
    always_comb begin
        state_n = state;
        hits_n  = hits;
        mis_n   = mis;
        phase_n = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
        // seen remembers an off-boundary token since the last boundary
        seen_n  = boundary ? 1'b0 : (seen | token_match);
        case (state)
            SEARCH: begin
                if (token_match) begin
                    phase_n = 4'd1;
                    hits_n  = 4'd1;
                    state_n = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (token_match) begin
                        if (hits + 4'd1 == LOCK_N) begin
                            state_n = LOCKED;
                            hits_n  = 4'd0;
                        end else begin
                            hits_n = hits + 4'd1;
                        end
                    end else begin
                        state_n = SEARCH;
                        hits_n  = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (token_match) begin
                        mis_n = 4'd0;
                    end else if (seen) begin
                        if (mis + 4'd1 == UNLOCK_N) begin
                            state_n = SEARCH;
                            mis_n   = 4'd0;
                            hits_n  = 4'd0;
                        end else begin
                            mis_n = mis + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_n = SEARCH;
                hits_n  = 4'd0;
                mis_n   = 4'd0;
            end
        endcase
    end

    // Output decode from state: emit only on boundaries that keep lock.
    always_comb begin
        locked    = (state == LOCKED);
        state_dbg = state;
        emit      = (state == LOCKED) && boundary && (state_n == LOCKED);
    end

    // Output register: one decoded word per emitted boundary, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= 8'h00;
            ctrl_out  <= 2'b00;
            de_out    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= emit;
            if (emit) begin
                if (token_match) begin
                    ctrl_out <= token_val;
                    de_out   <= 1'b0;
                end else begin
                    data_out <= dec_data;
                    de_out   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Bench for tmds_rx_channel: directed lock/decode/slip/reset scenarios plus
// randomized token/data bursts, all checked every cycle against a model
// built from a bit history and an absolute word-alignment anchor.
module tb_tmds_rx_channel;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 8;
    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0AB;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2AB;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       valid_out;
    logic       locked;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    tmds_rx_channel #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .serial_in(serial_in),
        .data_out (data_out),
        .ctrl_out (ctrl_out),
        .de_out   (de_out),
        .valid_out(valid_out),
        .locked   (locked),
        .state_dbg(state_dbg)
    );

    logic [9:0] toks [4] = '{TOK0, TOK1, TOK2, TOK3};

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_tok(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == toks[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] tok_val(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == toks[i]) return 2'(i);
        return 2'b00;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] x;
        b = q[9] ? ~q[7:0] : q[7:0];
        x = b ^ {b[6:0], 1'b0};
        if (!q[8]) x = {~x[7:1], x[0]};
        return x;
    endfunction

    localparam int MS = 0;
    localparam int MV = 1;
    localparam int ML = 2;

    bit         hist[$];
    bit         mh[$];
    int         m_e, m_anchor, m_mode, m_hits, m_mis;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic       m_de, m_valid, m_locked;

    task automatic model_step(input logic rst, input logic b);
        logic [9:0] w;
        bit tok, bnd, recent;
        if (rst) begin
            hist.delete();
            repeat (10) hist.push_back(1'b0);
            mh.delete();
            m_e = 0; m_anchor = 0; m_mode = MS; m_hits = 0; m_mis = 0;
            m_data = 8'h00; m_ctrl = 2'b00; m_de = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
            return;
        end
        for (int i = 0; i < 10; i++) w[i] = hist[hist.size() - 10 + i];
        tok = is_tok(w);
        bnd = ((m_e - m_anchor) % 10) == 0;
        recent = 1'b0;
        foreach (mh[i]) recent |= mh[i];
        m_valid = 1'b0;
        if (m_mode == MS) begin
            if (tok) begin
                m_anchor = m_e; m_hits = 1; m_mode = MV;
            end
        end else if (m_mode == MV) begin
            if (bnd) begin
                if (tok) begin
                    m_hits++;
                    if (m_hits == LOCK_COUNT) begin
                        m_mode = ML; m_hits = 0; m_mis = 0;
                    end
                end else begin
                    m_mode = MS; m_hits = 0;
                end
            end
        end else begin
            if (bnd) begin
                if (tok) m_mis = 0;
                else if (recent) m_mis++;
                if (m_mis == UNLOCK_COUNT) begin
                    m_mode = MS; m_mis = 0; m_hits = 0;
                end else begin
                    m_valid = 1'b1;
                    if (tok) begin
                        m_ctrl = tok_val(w); m_de = 1'b0;
                    end else begin
                        m_data = decode(w); m_de = 1'b1;
                    end
                end
            end
        end
        m_locked = (m_mode == ML);
        mh.push_back(tok);
        if (mh.size() > 9) void'(mh.pop_front());
        hist.push_back(b);
        void'(hist.pop_front());
        m_e++;
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(posedge clk) begin
        #1;
        model_step(reset, serial_in);
        check("data_out", 32'(data_out), 32'(m_data));
        check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
        check("de_out", 32'(de_out), 32'(m_de));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("locked", 32'(locked), 32'(m_locked));
        if (valid_out) got_q.push_back({de_out, ctrl_out, data_out});
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'h0);
        check({tag, "_ctrl"}, 32'(ctrl_out), 32'h0);
        check({tag, "_de"}, 32'(de_out), 32'h0);
        check({tag, "_valid"}, 32'(valid_out), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] tw;
        int fall_at, rise_at, n;

        // pin the decode rule with hand-worked words
        check("pin_dec_100", 32'(decode(10'h100)), 32'h00);
        check("pin_dec_200", 32'(decode(10'h200)), 32'hFF);
        check("pin_dec_10f", 32'(decode(10'h10F)), 32'h11);
        check("pin_dec_2f0", 32'(decode(10'h2F0)), 32'hEF);

        // lock at an odd offset, then decode data and control words
        do_reset();
        check_zero("reset");
        got_q.delete();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_word(TOK0);
        check("lock_before_4th", 32'(locked), 32'h0);
        tw = TOK0;
        send_bit(tw[0]);
        check("lock_after_4th", 32'(locked), 32'h1);
        for (int i = 1; i < 10; i++) send_bit(tw[i]);
        check("first_valid_early", 32'(valid_out), 32'h0);
        tw = 10'h100;
        send_bit(tw[0]);
        check("first_valid", 32'(valid_out), 32'h1);
        check("first_de", 32'(de_out), 32'h0);
        check("first_ctrl", 32'(ctrl_out), 32'h0);
        for (int i = 1; i < 10; i++) send_bit(tw[i]);
        send_word(10'h200);
        send_word(TOK1);
        send_word(TOK2);
        send_word(TOK3);
        send_word(TOK0);
        exp_q.delete();
        exp_q.push_back({1'b0, 2'b00, 8'h00});
        exp_q.push_back({1'b1, 2'b00, 8'h00});
        exp_q.push_back({1'b1, 2'b00, 8'hFF});
        exp_q.push_back({1'b0, 2'b01, 8'hFF});
        exp_q.push_back({1'b0, 2'b10, 8'hFF});
        exp_q.push_back({1'b0, 2'b11, 8'hFF});
        check("dir_word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check("dir_word", 32'(got_q[i]), 32'(exp_q[i]));

        // verify abort, then four fresh tokens to lock
        do_reset();
        got_q.delete();
        send_word(TOK0); send_word(TOK0);
        send_word(10'h100);
        check("abort_unlocked", 32'(locked), 32'h0);
        repeat (3) send_word(TOK0);
        check("abort_3_fresh", 32'(locked), 32'h0);
        send_word(TOK0);
        send_bit(1'b0);
        check("abort_relock", 32'(locked), 32'h1);
        check("abort_no_valid", 32'(got_q.size()), 32'h0);

        // bit slip on a 0x2AB stream
        do_reset();
        repeat (6) send_word(TOK3);
        check("slip_locked", 32'(locked), 32'h1);
        send_bit(1'b0);
        fall_at = -1;
        rise_at = -1;
        tw = TOK3;
        for (int i = 0; i < 200; i++) begin
            send_bit(tw[i % 10]);
            if (i == 69) check("slip_hold", 32'(locked), 32'h1);
            if (fall_at < 0 && !locked) fall_at = i;
            if (fall_at >= 0 && rise_at < 0 && locked) rise_at = i;
        end
        check("slip_unlock_seen", 32'(fall_at >= 79), 32'h1);
        check("slip_relock_seen", 32'(rise_at > fall_at && rise_at - fall_at <= 45), 32'h1);

        // reset while locked mid-word
        do_reset();
        repeat (5) send_word(TOK0);
        tw = 10'h100;
        for (int i = 0; i < 5; i++) send_bit(tw[i]);
        check("mid_locked", 32'(locked), 32'h1);
        reset = 1'b1;
        send_bit(1'b0);
        check_zero("mid_reset");
        reset = 1'b0;
        got_q.delete();
        repeat (3) send_word(TOK0);
        check("mid_no_lock", 32'(locked), 32'h0);
        check("mid_no_valid", 32'(got_q.size()), 32'h0);
        send_word(TOK0);
        send_bit(1'b0);
        check("mid_relock", 32'(locked), 32'h1);

        // randomized token/data bursts with occasional slips and a reset
        do_reset();
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(3, 12);
            tw = toks[$urandom_range(0, 3)];
            repeat (n) begin
                if ($urandom_range(0, 3) == 0) send_word(toks[$urandom_range(0, 3)]);
                else send_word(tw);
            end
            n = $urandom_range(1, 14);
            repeat (n) begin
                if ($urandom_range(0, 9) < 6) send_word(10'($urandom_range(0, 1023)));
                else send_word(toks[$urandom_range(0, 3)]);
            end
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 9)) send_bit(1'($urandom_range(0, 1)));
            if (k == 30) begin
                reset = 1'b1;
                send_bit(1'b0);
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
